// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, PC stride and the
// basic instruction-word types used by fetch and decode.
package fetch_unit_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Byte distance between consecutive sequential fetches.
    localparam int PC_STEP = 4;

    typedef logic [XLEN_DEFAULT-1:0] instr_word_t;
    typedef logic [XLEN_DEFAULT-1:0] fetch_addr_t;

    // S_REQ: request presented; S_WAIT: awaiting response; S_HOLD: word offered to decoder.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    // True when an address is not aligned to a 32-bit instruction word.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit and its environment: instruction-memory
// request/response, redirect from execute, and the decoder-facing word.
//
// Handshake rules: a request transfers on a clock edge where
// imem_req_valid && imem_req_ready; the producer keeps valid and address
// stable until that edge. imem_rsp_valid is a one-cycle pulse with no
// back-pressure, one per accepted request. The decoder word transfers on an
// edge where instr_valid && instr_ready; instr/instr_pc stay stable while
// instr_valid is high and not yet consumed. redirect_valid is a one-cycle pulse.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            misalign_err;

    // Fetch unit side.
    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr, instr_pc, misalign_err,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );

    // Memory / execute / decoder side.
    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc, misalign_err,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one memory request
// outstanding, holds the returned word for the decoder, and applies
// redirects from execute while discarding stale in-flight or held words.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic         CLK,
    input  logic         reset,
    fetch_unit_if.master bus,
    output fetch_state_t dbg_state_o
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            instr_valid_q, instr_valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            misalign_q, misalign_d;
    logic            req_valid;
    logic            req_fire;

    // Request is held low while reset is asserted so nothing leaks out
    // during reset; it may rise in the first cycle after release.
    assign req_valid = (state_q == S_REQ) && reset;
    assign req_fire  = req_valid && bus.imem_req_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc_q;
    assign bus.instr_valid    = instr_valid_q;
    assign bus.instr          = instr_q;
    assign bus.instr_pc       = instr_pc_q;
    assign bus.misalign_err   = misalign_q;
    assign dbg_state_o        = state_q;

    // Next-state: normal fetch sequencing, then redirect overrides everything.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_d        = kill_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        misalign_d    = 1'b0;

        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (kill_q) begin
                        // Response belongs to a fetch made before a redirect.
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d       = bus.imem_rsp_data;
                        instr_pc_d    = pc_q;
                        pc_d          = pc_q + XLEN'(PC_STEP);
                        instr_valid_d = 1'b1;
                        state_d       = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (bus.redirect_valid) begin
            pc_d          = {bus.redirect_pc[XLEN-1:2], 2'b00};
            instr_valid_d = 1'b0;
            instr_d       = instr_q;
            instr_pc_d    = instr_pc_q;
            misalign_d    = is_misaligned(bus.redirect_pc[1:0]);
            // A request still owes a response only if it was in flight and
            // not answered this cycle, or it is being accepted right now.
            if (((state_q == S_WAIT) && !bus.imem_rsp_valid) || req_fire) begin
                kill_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                kill_d  = 1'b0;
                state_d = S_REQ;
            end
        end
    end

    // State, PC, kill flag and decoder-facing output registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            kill_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_q        <= kill_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            misalign_q    <= misalign_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-configurable memory responder, a
// transaction-level model of the fetch stream checked every cycle, and
// directed scenarios with hand-computed expectations.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic         clk;
    logic         reset;
    fetch_state_t dbg_state;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .CLK         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    // ---------------- counters and scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;
    int lat         = 0;
    bit inject      = 1'b0;

    logic [63:0] exp_q[$];   // {pc, word} the decoder must see, in order
    logic [31:0] exp_addr;
    bit          pend;
    bit          pend_stale;
    logic [31:0] pend_addr;
    bit          exp_mis;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00A0_0113;
            default:       return {a[15:0], ~a[31:16]};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_instr(input string name);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.instr_valid) break;
        end
        check(name, {31'b0, bus.instr_valid}, 32'd1);
    endtask

    task automatic wait_req(input string name);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.imem_req_valid) break;
        end
        check(name, {31'b0, bus.imem_req_valid}, 32'd1);
    endtask

    // ---------------- memory responder ----------------
    initial begin : responder
        bit          busy;
        int          cnt;
        logic [31:0] maddr;
        bit          acc;
        logic [31:0] acc_addr;
        busy = 1'b0;
        cnt = 0;
        maddr = '0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            acc      = bus.imem_req_valid && bus.imem_req_ready;
            acc_addr = bus.imem_addr;
            @(posedge clk);
            #2;
            bus.imem_rsp_valid = 1'b0;
            if (acc) begin
                busy  = 1'b1;
                cnt   = lat;
                maddr = acc_addr;
            end
            if (busy) begin
                if (cnt == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mem_word(maddr);
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (inject) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = 32'hDEAD_BEEF;
                inject = 1'b0;
            end
        end
    end

    // ---------------- per-cycle model compare ----------------
    initial begin : monitor
        bit          exp_req;
        bit          redir;
        bit          acc;
        bit          rsp;
        logic [31:0] rtgt;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                pend       = 1'b0;
                pend_stale = 1'b0;
                exp_addr   = 32'h0;
                exp_mis    = 1'b0;
            end else begin
                exp_req = !pend && (exp_q.size() == 0);
                check("mon_req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_req});
                if (exp_req) check("mon_addr", bus.imem_addr, exp_addr);
                check("mon_instr_valid", {31'b0, bus.instr_valid}, {31'b0, exp_q.size() != 0});
                if (exp_q.size() != 0) begin
                    check("mon_instr", bus.instr, exp_q[0][31:0]);
                    check("mon_instr_pc", bus.instr_pc, exp_q[0][63:32]);
                end
                check("mon_misalign", {31'b0, bus.misalign_err}, {31'b0, exp_mis});

                redir = bus.redirect_valid;
                rtgt  = bus.redirect_pc;
                acc   = exp_req && bus.imem_req_ready;
                rsp   = pend && bus.imem_rsp_valid;
                if ((exp_q.size() != 0) && bus.instr_ready && !redir) void'(exp_q.pop_front());
                if (rsp) begin
                    if (!pend_stale && !redir) begin
                        exp_q.push_back({pend_addr, mem_word(pend_addr)});
                        exp_addr = pend_addr + 32'd4;
                    end
                    pend = 1'b0;
                end
                if (acc) begin
                    pend       = 1'b1;
                    pend_stale = 1'b0;
                    pend_addr  = exp_addr;
                end
                if (redir) begin
                    exp_q.delete();
                    exp_addr = {rtgt[31:2], 2'b00};
                    if (pend) pend_stale = 1'b1;
                    exp_mis = (rtgt[1:0] != 2'b00);
                end else begin
                    exp_mis = 1'b0;
                end
            end
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        reset              = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // Reset held for 5 cycles.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check("rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_instr_pc", bus.instr_pc, 32'h0);
        check("rst_misalign", {31'b0, bus.misalign_err}, 32'd0);
        check("rst_state", {30'b0, dbg_state}, {30'b0, S_REQ});
        step();
        reset = 1'b1;
        @(negedge clk);
        check("rel_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check("rel_addr", bus.imem_addr, 32'h0);

        // Straight-line, zero-wait memory.
        wait_instr("sl_wait0");
        check("sl_instr0", bus.instr, 32'h0050_0093);
        check("sl_pc0", bus.instr_pc, 32'h0);
        wait_instr("sl_wait1");
        check("sl_instr1", bus.instr, 32'h00A0_0113);
        check("sl_pc1", bus.instr_pc, 32'h4);
        wait_req("sl_wait_req");
        check("sl_next_addr", bus.imem_addr, 32'h8);

        // Back-pressure in S_HOLD, with a stray response on the bus.
        step();
        bus.instr_ready = 1'b0;
        wait_instr("bp_wait");
        check("bp_pc", bus.instr_pc, 32'h8);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 1) inject = 1'b1;
            @(negedge clk);
            check("bp_pc_stable", bus.instr_pc, 32'h8);
            check("bp_instr_stable", bus.instr, mem_word(32'h8));
            check("bp_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        end
        step();
        bus.instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_req_after", {31'b0, bus.imem_req_valid}, 32'd1);
        check("bp_addr_after", bus.imem_addr, 32'hC);

        // Redirect while waiting on a slow response.
        step();
        lat = 3;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        wait_req("rif_wait_req");
        check("rif_addr", bus.imem_addr, 32'h100);
        wait_instr("rif_wait_instr");
        check("rif_pc", bus.instr_pc, 32'h100);
        check("rif_instr", bus.instr, mem_word(32'h100));

        // Redirect in S_HOLD while the decoder is consuming.
        step();
        bus.instr_ready = 1'b0;
        wait_instr("rvc_wait");
        check("rvc_pc", bus.instr_pc, 32'h104);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        bus.instr_ready    = 1'b1;
        @(negedge clk);
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("rvc_valid_dropped", {31'b0, bus.instr_valid}, 32'd0);
        check("rvc_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check("rvc_addr", bus.imem_addr, 32'h40);

        // Misaligned redirect target.
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        @(negedge clk);
        check("mis_before", {31'b0, bus.misalign_err}, 32'd0);
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("mis_pulse", {31'b0, bus.misalign_err}, 32'd1);
        step();
        @(negedge clk);
        check("mis_after", {31'b0, bus.misalign_err}, 32'd0);
        wait_req("mis_wait_req");
        check("mis_addr", bus.imem_addr, 32'h100);

        // PC wrap at the top of the address space.
        step();
        lat = 0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        wait_req("wrap_wait_req");
        check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        wait_instr("wrap_wait_instr");
        check("wrap_pc", bus.instr_pc, 32'hFFFF_FFFC);
        wait_req("wrap_wait_next");
        check("wrap_next_addr", bus.imem_addr, 32'h0);

        // Redirect in the same cycle a request is accepted.
        step();
        bus.imem_req_ready = 1'b0;
        wait_req("acc_wait_stall");
        check("acc_stall_addr", bus.imem_addr, 32'h4);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        bus.imem_req_ready = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        wait_req("acc_wait_req");
        check("acc_addr", bus.imem_addr, 32'h200);
        wait_instr("acc_wait_instr");
        check("acc_pc", bus.instr_pc, 32'h200);

        // Back-to-back redirects: the last one wins.
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        step();
        bus.redirect_pc    = 32'h304;
        step();
        bus.redirect_valid = 1'b0;
        wait_req("b2b_wait_req");
        check("b2b_addr", bus.imem_addr, 32'h304);
        wait_instr("b2b_wait_instr");
        check("b2b_pc", bus.instr_pc, 32'h304);

        // Reset mid-transaction; the late response must be ignored.
        wait_req("rmt_wait_req");
        check("rmt_addr", bus.imem_addr, 32'h308);
        step();
        lat = 3;
        step();
        reset              = 1'b0;
        bus.imem_req_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        step();
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        check("rmt_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check("rmt_addr0", bus.imem_addr, 32'h0);
        wait_instr("rmt_wait_instr");
        check("rmt_pc", bus.instr_pc, 32'h0);
        check("rmt_instr", bus.instr, 32'h0050_0093);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
